// File: rtl/split_join_arbiter_pkg.sv
// Shared types for the split/join arbiter: split/join request payloads,
// default IPDOM stack depth and the optional performance-counter bundle.
package split_join_arbiter_pkg;

    localparam int SJ_NUM_THREADS = 4;
    localparam int SJ_XLEN        = 32;
    localparam int SJ_STACK_DEPTH = (SJ_NUM_THREADS > 1) ? SJ_NUM_THREADS - 1 : 1;

    typedef struct packed {
        logic                      valid;
        logic                      is_dvg;
        logic [SJ_NUM_THREADS-1:0] then_tmask;
        logic [SJ_NUM_THREADS-1:0] else_tmask;
        logic [SJ_XLEN-1:0]        next_pc;
    } split_t;

    typedef struct packed {
        logic valid;
        logic is_dvg;
    } join_t;

    typedef struct packed {
        logic [31:0] splits;
        logic [31:0] joins;
        logic [31:0] stalls;
    } sj_arb_perf_t;

endpackage

// File: rtl/split_join_dvg_tracker.sv
// One warp's divergence tracker: mirrors IPDOM stack occupancy and the
// per-level else-pending phase bit of the downstream split/join unit.
module split_join_dvg_tracker
    import split_join_arbiter_pkg::*;
#(
    parameter int DEPTH = SJ_STACK_DEPTH
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic udf
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    cnt;
    logic [DEPTH-1:0] phase;
    logic [CW-1:0]    top;

    assign top   = cnt - CW'(1);
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign udf   = pop & empty;

    // A join on a level whose else path is still pending only flips the phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= '0;
        end else if (push && !full) begin
            phase[cnt] <= 1'b1;
            cnt        <= cnt + CW'(1);
        end else if (pop && !empty) begin
            if (phase[top]) begin
                phase[top] <= 1'b0;
            end else begin
                cnt <= top;
            end
        end
    end

endmodule

// File: rtl/split_join_arbiter.sv
// Round-robin arbiter sharing one split/join unit between ALU issue blocks.
// Optional macro SPLIT_JOIN_ARB_PERF_EN adds perf_splits/perf_joins/perf_stalls.
module split_join_arbiter
    import split_join_arbiter_pkg::*;
#(
    parameter int NUM_REQS    = 2,
    parameter int NUM_WARPS   = 4,
    parameter int NW_WIDTH    = 2,
    parameter int NUM_THREADS = SJ_NUM_THREADS,
    parameter int XLEN        = SJ_XLEN,
    parameter int STACK_DEPTH = SJ_STACK_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQS-1:0]             req_valid,
    output logic [NUM_REQS-1:0]             req_ready,
    input  logic [NUM_REQS*NW_WIDTH-1:0]    req_wid,
    input  logic [NUM_REQS-1:0]             req_is_split,
    input  logic [NUM_REQS-1:0]             req_is_dvg,
    input  logic [NUM_REQS*NUM_THREADS-1:0] req_then_tmask,
    input  logic [NUM_REQS*NUM_THREADS-1:0] req_else_tmask,
    input  logic [NUM_REQS*XLEN-1:0]        req_next_pc,
    output logic                            out_valid,
    output logic [NW_WIDTH-1:0]             out_wid,
    output split_t                          out_split,
    output join_t                           out_join,
    output logic [NUM_WARPS-1:0]            warp_dvg_full,
    output logic                            ovf_err,
    output logic                            udf_err
`ifdef SPLIT_JOIN_ARB_PERF_EN
    ,
    output logic [31:0]                     perf_splits,
    output logic [31:0]                     perf_joins,
    output logic [31:0]                     perf_stalls
`endif
);

    localparam int PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          grant_idx;
    logic [PW-1:0]          cand_idx;
    logic [PW:0]            cand_sum;
    logic                   found;
    logic [NUM_REQS-1:0]    grant;
    logic [NUM_REQS-1:0]    eligible;
    logic [NUM_REQS-1:0]    split_blocked;

    logic                   sel_split;
    logic                   sel_dvg;
    logic [NW_WIDTH-1:0]    sel_wid;
    logic [NUM_THREADS-1:0] sel_then;
    logic [NUM_THREADS-1:0] sel_else;
    logic [XLEN-1:0]        sel_pc;
    logic                   drop;
    logic                   ovf_hit;

    logic [NUM_WARPS-1:0]   trk_push;
    logic [NUM_WARPS-1:0]   trk_pop;
    logic [NUM_WARPS-1:0]   trk_full;
    logic [NUM_WARPS-1:0]   trk_empty;
    logic [NUM_WARPS-1:0]   trk_udf;

    // The unit's join result is pipelined, so a warp just joined sits out one cycle.
    for (genvar r = 0; r < NUM_REQS; r++) begin : g_req
        logic [NW_WIDTH-1:0] wid;
        logic                hazard;
        assign wid              = req_wid[r*NW_WIDTH +: NW_WIDTH];
        assign split_blocked[r] = req_is_split[r] & req_is_dvg[r] & trk_full[wid];
        assign hazard           = out_valid & out_join.valid & (wid == out_wid);
        assign eligible[r]      = req_valid[r] & ~split_blocked[r] & ~hazard;
    end

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cand_sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand_sum >= (PW+1)'(NUM_REQS)) begin
                cand_sum = cand_sum - (PW+1)'(NUM_REQS);
            end
            cand_idx = cand_sum[PW-1:0];
            if (!found && eligible[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant = '0;
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant;

    always_comb begin
        sel_split = 1'b0;
        sel_dvg   = 1'b0;
        sel_wid   = '0;
        sel_then  = '0;
        sel_else  = '0;
        sel_pc    = '0;
        for (int r = 0; r < NUM_REQS; r++) begin
            if (grant[r]) begin
                sel_split = req_is_split[r];
                sel_dvg   = req_is_dvg[r];
                sel_wid   = req_wid[r*NW_WIDTH +: NW_WIDTH];
                sel_then  = req_then_tmask[r*NUM_THREADS +: NUM_THREADS];
                sel_else  = req_else_tmask[r*NUM_THREADS +: NUM_THREADS];
                sel_pc    = req_next_pc[r*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        trk_push = '0;
        trk_pop  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            trk_push[w] = found & sel_split & sel_dvg & (sel_wid == NW_WIDTH'(w));
            trk_pop[w]  = found & ~sel_split & sel_dvg & (sel_wid == NW_WIDTH'(w));
        end
    end

    // Underflowing joins are consumed but never reach the unit.
    assign drop    = found & ~sel_split & sel_dvg & trk_empty[sel_wid];
    assign ovf_hit = |(req_valid & split_blocked);

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_trk
        split_join_dvg_tracker #(
            .DEPTH (STACK_DEPTH)
        ) u_trk (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (trk_push[w]),
            .pop     (trk_pop[w]),
            .full    (trk_full[w]),
            .empty   (trk_empty[w]),
            .udf     (trk_udf[w])
        );
    end

    assign warp_dvg_full = trk_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_wid   <= '0;
            out_split <= '0;
            out_join  <= '0;
            rr_ptr    <= '0;
            ovf_err   <= 1'b0;
            udf_err   <= 1'b0;
        end else begin
            out_valid <= found & ~drop;
            out_wid   <= sel_wid;
            out_split <= '0;
            out_join  <= '0;
            if (found && !drop) begin
                if (sel_split) begin
                    out_split.valid      <= 1'b1;
                    out_split.is_dvg     <= sel_dvg;
                    out_split.then_tmask <= sel_then;
                    out_split.else_tmask <= sel_else;
                    out_split.next_pc    <= sel_pc;
                end else begin
                    out_join.valid  <= 1'b1;
                    out_join.is_dvg <= sel_dvg;
                end
            end
            if (found) begin
                rr_ptr <= (grant_idx == PW'(NUM_REQS - 1)) ? '0 : grant_idx + PW'(1);
            end
            if (ovf_hit) begin
                ovf_err <= 1'b1;
            end
            if (|trk_udf) begin
                udf_err <= 1'b1;
            end
        end
    end

`ifdef SPLIT_JOIN_ARB_PERF_EN
    sj_arb_perf_t perf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else begin
            perf_q.splits <= perf_q.splits + 32'(found & sel_split & sel_dvg);
            perf_q.joins  <= perf_q.joins + 32'(found & ~sel_split & sel_dvg & ~drop);
            perf_q.stalls <= perf_q.stalls + 32'((|req_valid) & ~found);
        end
    end

    assign perf_splits = perf_q.splits;
    assign perf_joins  = perf_q.joins;
    assign perf_stalls = perf_q.stalls;
`endif

endmodule

// File: tb/tb_split_join_arbiter.sv
// Directed, table-driven bench for split_join_arbiter (two requesters, four warps).
module tb_split_join_arbiter;
    import split_join_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_wid;
    logic [1:0]  req_is_split;
    logic [1:0]  req_is_dvg;
    logic [7:0]  req_then_tmask;
    logic [7:0]  req_else_tmask;
    logic [63:0] req_next_pc;
    logic        out_valid;
    logic [1:0]  out_wid;
    split_t      out_split;
    join_t       out_join;
    logic [3:0]  warp_dvg_full;
    logic        ovf_err;
    logic        udf_err;
`ifdef SPLIT_JOIN_ARB_PERF_EN
    logic [31:0] perf_splits;
    logic [31:0] perf_joins;
    logic [31:0] perf_stalls;
`endif

    split_join_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wid        (req_wid),
        .req_is_split   (req_is_split),
        .req_is_dvg     (req_is_dvg),
        .req_then_tmask (req_then_tmask),
        .req_else_tmask (req_else_tmask),
        .req_next_pc    (req_next_pc),
        .out_valid      (out_valid),
        .out_wid        (out_wid),
        .out_split      (out_split),
        .out_join       (out_join),
        .warp_dvg_full  (warp_dvg_full),
        .ovf_err        (ovf_err),
        .udf_err        (udf_err)
`ifdef SPLIT_JOIN_ARB_PERF_EN
        ,
        .perf_splits    (perf_splits),
        .perf_joins     (perf_joins),
        .perf_stalls    (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] v;
        logic [1:0] w0;
        logic [1:0] w1;
        logic [1:0] sp;
        logic [1:0] dv;
        logic [1:0] rdy;
        logic       ov;
        logic [1:0] owid;
        logic       osp;
        logic [3:0] full;
        logic       ovf;
        logic       udf;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl[NV];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] w0, input logic [1:0] w1,
                                input logic [1:0] sp, input logic [1:0] dv, input logic [1:0] rdy,
                                input logic ov, input logic [1:0] owid, input logic osp,
                                input logic [3:0] full, input logic ovf, input logic udf);
        vec_t t;
        t.v = v; t.w0 = w0; t.w1 = w1; t.sp = sp; t.dv = dv; t.rdy = rdy;
        t.ov = ov; t.owid = owid; t.osp = osp; t.full = full; t.ovf = ovf; t.udf = udf;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w0, input logic [1:0] w1,
                         input logic [1:0] sp, input logic [1:0] dv);
        req_valid    = v;
        req_wid      = {w1, w0};
        req_is_split = sp;
        req_is_dvg   = dv;
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] w0, input logic [1:0] w1,
                        input logic [1:0] sp, input logic [1:0] dv);
        @(negedge clk);
        drive(v, w0, w1, sp, dv);
        @(posedge clk);
    endtask

    initial begin
        logic       win;
        logic [1:0] dvb;

        req_then_tmask = 8'hC3;
        req_else_tmask = 8'h3C;
        req_next_pc    = {32'h0000_2000, 32'h0000_1000};
        drive(2'b00, 2'd0, 2'd0, 2'b00, 2'b00);

        //           v      w0 w1 sp     dv     rdy    ov owid osp full     ovf   udf
        tbl[0]  = mk(2'b11, 0, 1, 2'b11, 2'b00, 2'b01, 1, 0, 1, 4'b0000, 1'b0, 1'b0);
        tbl[1]  = mk(2'b11, 0, 1, 2'b11, 2'b00, 2'b10, 1, 1, 1, 4'b0000, 1'b0, 1'b0);
        tbl[2]  = mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'b0000, 1'b0, 1'b0);
        tbl[3]  = mk(2'b01, 2, 0, 2'b01, 2'b01, 2'b01, 1, 2, 1, 4'b0000, 1'b0, 1'b0);
        tbl[4]  = mk(2'b01, 2, 0, 2'b01, 2'b01, 2'b01, 1, 2, 1, 4'b0000, 1'b0, 1'b0);
        tbl[5]  = mk(2'b01, 2, 0, 2'b01, 2'b01, 2'b01, 1, 2, 1, 4'b0100, 1'b0, 1'b0);
        tbl[6]  = mk(2'b01, 2, 0, 2'b01, 2'b01, 2'b00, 0, 0, 0, 4'b0100, 1'b1, 1'b0);
        tbl[7]  = mk(2'b01, 2, 0, 2'b00, 2'b01, 2'b01, 1, 2, 0, 4'b0100, 1'b1, 1'b0);
        tbl[8]  = mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'b0100, 1'b1, 1'b0);
        tbl[9]  = mk(2'b01, 0, 0, 2'b01, 2'b01, 2'b01, 1, 0, 1, 4'b0100, 1'b1, 1'b0);
        tbl[10] = mk(2'b01, 0, 0, 2'b00, 2'b01, 2'b01, 1, 0, 0, 4'b0100, 1'b1, 1'b0);
        tbl[11] = mk(2'b01, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 4'b0100, 1'b1, 1'b0);
        tbl[12] = mk(2'b01, 0, 0, 2'b00, 2'b01, 2'b01, 1, 0, 0, 4'b0100, 1'b1, 1'b0);
        tbl[13] = mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'b0100, 1'b1, 1'b0);
        tbl[14] = mk(2'b01, 0, 0, 2'b00, 2'b01, 2'b01, 0, 0, 0, 4'b0100, 1'b1, 1'b1);
        tbl[15] = mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'b0100, 1'b1, 1'b1);
        tbl[16] = mk(2'b10, 0, 3, 2'b10, 2'b00, 2'b10, 1, 3, 1, 4'b0100, 1'b1, 1'b1);
        tbl[17] = mk(2'b11, 1, 1, 2'b00, 2'b00, 2'b01, 1, 1, 0, 4'b0100, 1'b1, 1'b1);
        tbl[18] = mk(2'b10, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'b0100, 1'b1, 1'b1);
        tbl[19] = mk(2'b10, 1, 1, 2'b00, 2'b00, 2'b10, 1, 1, 0, 4'b0100, 1'b1, 1'b1);
        tbl[20] = mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'b0100, 1'b1, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_wid", 64'(out_wid), 64'd0);
        chk("rst_out_split", 64'(out_split), 64'd0);
        chk("rst_out_join", 64'(out_join), 64'd0);
        chk("rst_full", 64'(warp_dvg_full), 64'd0);
        chk("rst_errs", 64'({ovf_err, udf_err}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].w0, tbl[i].w1, tbl[i].sp, tbl[i].dv);
            #1;
            chk($sformatf("ready[%0d]", i), 64'(req_ready), 64'(tbl[i].rdy));
            win = tbl[i].rdy[1];
            dvb = tbl[i].dv;
            @(posedge clk);
            #1;
            chk($sformatf("out_valid[%0d]", i), 64'(out_valid), 64'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("out_wid[%0d]", i), 64'(out_wid), 64'(tbl[i].owid));
                chk($sformatf("split_valid[%0d]", i), 64'(out_split.valid), 64'(tbl[i].osp));
                chk($sformatf("join_valid[%0d]", i), 64'(out_join.valid), 64'(!tbl[i].osp));
                if (tbl[i].osp) begin
                    chk($sformatf("split_dvg[%0d]", i), 64'(out_split.is_dvg), 64'(dvb[win]));
                    chk($sformatf("split_pc[%0d]", i), 64'(out_split.next_pc),
                        win ? 64'h2000 : 64'h1000);
                    chk($sformatf("split_then[%0d]", i), 64'(out_split.then_tmask),
                        win ? 64'hC : 64'h3);
                end else begin
                    chk($sformatf("join_dvg[%0d]", i), 64'(out_join.is_dvg), 64'(dvb[win]));
                end
            end
            chk($sformatf("full[%0d]", i), 64'(warp_dvg_full), 64'(tbl[i].full));
            chk($sformatf("ovf[%0d]", i), 64'(ovf_err), 64'(tbl[i].ovf));
            chk($sformatf("udf[%0d]", i), 64'(udf_err), 64'(tbl[i].udf));
        end

        // Reset asserted while a forwarded request is on the output.
        @(negedge clk);
        drive(2'b01, 2'd1, 2'd0, 2'b01, 2'b01);
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_split", 64'(out_split), 64'd0);
        chk("mid_rst_full", 64'(warp_dvg_full), 64'd0);
        chk("mid_rst_errs", 64'({ovf_err, udf_err}), 64'd0);
        @(negedge clk);
        drive(2'b11, 2'd0, 2'd1, 2'b11, 2'b00);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'b01);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 64'(out_valid), 64'd1);
        chk("post_rst_out_wid", 64'(out_wid), 64'd0);

`ifdef SPLIT_JOIN_ARB_PERF_EN
        repeat (3) step(2'b01, 2'd0, 2'd0, 2'b01, 2'b01);
        repeat (2) step(2'b01, 2'd1, 2'd0, 2'b01, 2'b01);
        repeat (3) step(2'b01, 2'd0, 2'd0, 2'b01, 2'b01);
        for (int j = 0; j < 5; j++) begin
            step(2'b01, 2'd0, 2'd0, 2'b00, 2'b01);
            step(2'b00, 2'd0, 2'd0, 2'b00, 2'b00);
        end
        #1;
        chk("perf_splits", 64'(perf_splits), 64'd5);
        chk("perf_joins", 64'(perf_joins), 64'd5);
        chk("perf_stalls", 64'(perf_stalls), 64'd3);
        chk("perf_full", 64'(warp_dvg_full), 64'b0000);
        chk("perf_errs", 64'({ovf_err, udf_err}), 64'b10);
`endif

        @(negedge clk);
        drive(2'b00, 2'd0, 2'd0, 2'b00, 2'b00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
